// File: rtl/dcntr_timer_pkg.sv
// Shared types and helpers for the round-robin down-counter timer arbiter.
package dcntr_timer_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req searching upward from ptr, wrapping modulo n (n <= 8).
  // Walking the offsets from high to low lets the smallest offset win last.
  function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (req[j]) begin
          p.valid = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dcntr_timer_arb_if.sv
// Requester-side bundle of the timer arbiter: level requests and lengths in,
// grant / done / busy / counter value out.
interface dcntr_timer_arb_if
  import dcntr_timer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt;

  modport master (output req, len, input gnt, done, busy, cnt);
  modport slave  (input req, len, output gnt, done, busy, cnt);
endinterface

// File: rtl/dcntr_load.sv
// W-bit down-counter: async reset, synchronous clear/load, decrement enable,
// combinational zero flag.
module dcntr_load #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dcntr_timer_arb.sv
// Round-robin arbiter granting one requester at a time the shared down-counter
// and returning a one-cycle done pulse when its interval expires.
module dcntr_timer_arb
  import dcntr_timer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input logic              clk,
  input logic              reset,
  dcntr_timer_arb_if.slave bus
);

  state_t       state;
  logic [2:0]   ptr;
  logic [2:0]   owner;
  logic [7:0]   req_ext;
  pick_t        pick;
  logic [W-1:0] len_sel;
  logic [2:0]   ptr_nxt;
  logic         cnt_zero;
  logic         cnt_clr;
  logic         cnt_load;
  logic         cnt_dec;

  function automatic logic [N-1:0] onehot(input logic [2:0] i);
    logic [7:0] t;
    t = 8'd1 << i;
    return t[N-1:0];
  endfunction

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = bus.req;
  end

  assign pick    = rr_pick(req_ext, ptr, N);
  assign len_sel = bus.len[int'(pick.idx)*W +: W];
  assign ptr_nxt = (int'(owner) == N - 1) ? 3'd0 : owner + 3'd1;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE:  cnt_load = pick.valid;
      COUNT: begin
        if (!req_ext[owner]) cnt_clr = 1'b1;
        else if (!cnt_zero)  cnt_dec = 1'b1;
      end
      default: ;
    endcase
  end

  dcntr_load #(.W(W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (len_sel),
    .cnt      (bus.cnt),
    .zero     (cnt_zero)
  );

  // Abort is checked before the zero test so a request dropped on the last
  // count cycle never produces a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      bus.gnt  <= '0;
      bus.done <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.valid) begin
            state    <= COUNT;
            owner    <= pick.idx;
            bus.gnt  <= onehot(pick.idx);
            bus.busy <= 1'b1;
          end
        end
        COUNT: begin
          if (!req_ext[owner]) begin
            state    <= IDLE;
            ptr      <= ptr_nxt;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
          end else if (cnt_zero) begin
            state    <= DONE;
            bus.done <= onehot(owner);
          end
        end
        DONE: begin
          state    <= IDLE;
          ptr      <= ptr_nxt;
          bus.gnt  <= '0;
          bus.done <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.done <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dcntr_timer_arb.md
Name: dcntr_timer_arb

Overview:
Round-robin arbiter that shares one loadable down-counter between N requesters. Each requester asks for a timed interval of `len` ticks. The block grants one requester at a time, loads the counter with that requester's length and counts down to zero. It then returns a one-cycle done pulse to the granted requester. It sits between client FSMs and the shared 4-bit down-counter datapath.

Parameters:
N, 4, number of requesters (2..8)
W, 4, counter / length width in bits

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N  per-requester request level; held high until done or abort
len  input  N*W  flattened lengths; requester i uses len[i*W +: W]
gnt  output  N  one-hot grant, registered; zero when idle
done  output  N  one-hot, one-cycle completion pulse, registered
busy  output  1  high in COUNT and DONE
cnt  output  W  current counter value, registered

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. While reset is high:
  - state=IDLE
  - gnt=0, done=0, busy=0, cnt=0
  - round-robin pointer ptr=0
  - Reset asserted mid-operation aborts immediately; no done is issued.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req!=0, pick the winner g = first set bit searching from ptr upward, wrapping modulo N.
  - Next edge: gnt<=onehot(g), cnt<=len[g], state<=COUNT.
  - len is sampled only on this edge; later changes to len are ignored.
  - If req==0, stay in IDLE with gnt=0.
- COUNT:
  - If req[g]==0 (abort): next edge state<=IDLE, gnt<=0, cnt<=0, ptr<=(g+1) mod N; no done pulse.
  - Else if cnt==0: state<=DONE, done<=onehot(g).
  - Else: cnt<=cnt-1. Arithmetic is modulo 2^W, but cnt never underflows because the zero check comes first.
- DONE:
  - done[g]=1 for exactly this cycle; gnt still asserted.
  - Next edge: done<=0, gnt<=0, ptr<=(g+1) mod N, state<=IDLE.
- Latency:
  - For length L, COUNT lasts L+1 cycles (cnt shows L, L-1, ..., 0).
  - done is high during cycle L+1 after the grant edge.
  - L=0 is legal: one COUNT cycle, then DONE.
- Throughput: at least one IDLE cycle between grants. A slot for length L occupies L+3 cycles including that IDLE cycle.
- Requester protocol:
  - The requester should drop req in the cycle after done.
  - If req is still high in IDLE, it is treated as a new request, but at the lowest round-robin priority.
- Simultaneous events:
  - New requests during COUNT/DONE are queued implicitly (level-sensitive) and evaluated in IDLE.
  - An abort in the same cycle as cnt==0 takes precedence: no done is issued.
- Invariants: gnt is one-hot or zero; done is a subset of gnt; busy == (gnt != 0).

Decomposition:
- Package dcntr_timer_pkg holds:
  - state enum {IDLE, COUNT, DONE}
  - default constants N_DEF=4, W_DEF=4
  - a function rr_pick(req, ptr) returning the winner index and a valid flag
- One sub-module, dcntr_load: W-bit down-counter register with async reset, synchronous load, decrement enable, and a zero flag.
- The arbiter FSM and ptr live in the top module.

Test Plan (N=4, W=4):
1. req=0001, len0=3, asserted before edge E0:
   - gnt=0001 after E0
   - cnt=3,2,1,0 over 4 cycles
   - done=0001 for exactly 1 cycle (cycle 4 after E0)
   - gnt=0 the cycle after; ptr=1
2. req=1111, all len=1, held until each done:
   - grant order 0,1,2,3,0
   - each slot lasts 4 cycles including IDLE
   - done pulses in the same order, never two at once
3. req=0100, len2=0:
   - gnt=0100 after E0, cnt=0
   - done=0100 in cycle 1 after E0
   - IDLE in cycle 2
4. req=0100, len2=9; drop req2 while cnt=5:
   - next edge gnt=0, cnt=0, no done pulse
   - with pending req=1001, the next grant goes to requester 3 (ptr=3)
5. Assert reset asynchronously while cnt=6 mid-COUNT:
   - gnt, done, busy and cnt read 0 before the next clk edge
   - after release, the first grant with req=1111 goes to requester 0
6. len0=15 (max) at grant, len0 changed to 2 during COUNT:
   - cnt runs 15..0 (16 COUNT cycles)
   - done=0001 in cycle 16 after the grant edge
